// File: rtl/div_pkg.sv
// Shared definitions for the pipelined non-restoring divider: op encodings
// and the special-case tag that overrides the iterative result.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int OP_BIT_UNSIGNED = 0;
  localparam int OP_BIT_REM      = 1;

  // SPEC_DIV0: q = all ones, r = dividend; SPEC_OVF: q = dividend, r = 0
  typedef enum logic [1:0] {
    SPEC_NONE = 2'b00,
    SPEC_DIV0 = 2'b01,
    SPEC_OVF  = 2'b10
  } div_spec_e;

endpackage

// File: rtl/div_nr_stage.sv
// One combinational slice of the non-restoring divider: resolves
// BITS_PER_STAGE quotient bits on the {A, Q} register pair.
module div_nr_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_STAGE = 2
) (
  input  logic [DATA_WIDTH:0]   i_a,
  input  logic [DATA_WIDTH:0]   i_m,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic [DATA_WIDTH:0]   o_a,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH:0]   w_a;
  logic [DATA_WIDTH:0]   w_sh;
  logic [DATA_WIDTH-1:0] w_q;

  always_comb begin
    w_a  = i_a;
    w_q  = i_q;
    w_sh = '0;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      w_sh = {w_a[DATA_WIDTH-1:0], w_q[DATA_WIDTH-1]};
      w_a  = w_a[DATA_WIDTH] ? (w_sh + i_m) : (w_sh - i_m);
      w_q  = {w_q[DATA_WIDTH-2:0], ~w_a[DATA_WIDTH]};
    end
    o_a = w_a;
    o_q = w_q;
  end

endmodule

// File: rtl/div_pipe_nr.sv
// Fully pipelined RV32M divider (DIV/DIVU/REM/REMU), one op per cycle,
// valid/ready handshake with whole-pipe stall, tag passthrough and flush.
module div_pipe_nr
  import div_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int DW         = DATA_WIDTH;
  localparam int NUM_STAGES = DATA_WIDTH / BITS_PER_STAGE;
  localparam int NS         = NUM_STAGES;

  logic                 w_adv;
  logic                 r_out_valid;
  logic [DW-1:0]        r_out_result;
  logic [TAG_WIDTH-1:0] r_out_tag;

  // input conditioning
  logic          w_signed, w_sa, w_sb, w_div0, w_ovf, w_qneg;
  logic [DW-1:0] w_abs_a, w_abs_b;
  div_spec_e     w_spec;

  assign w_signed = ~in_op[OP_BIT_UNSIGNED];
  assign w_sa     = w_signed & in_dividend[DW-1];
  assign w_sb     = w_signed & in_divisor[DW-1];
  assign w_abs_a  = w_sa ? -in_dividend : in_dividend;
  assign w_abs_b  = w_sb ? -in_divisor : in_divisor;
  assign w_div0   = (in_divisor == '0);
  assign w_ovf    = w_signed & (in_dividend == {1'b1, {(DW-1){1'b0}}}) & (in_divisor == '1);
  assign w_qneg   = (w_sa ^ w_sb) & ~w_div0;
  assign w_spec   = w_div0 ? SPEC_DIV0 : (w_ovf ? SPEC_OVF : SPEC_NONE);

  // pipeline registers; index k holds the output of stage k
  logic [NS-1:0]        r_vld;
  logic [DW:0]          r_a    [NS];
  logic [DW-1:0]        r_q    [NS];
  logic [DW:0]          r_m    [NS];
  logic                 r_rem  [NS];
  logic                 r_qneg [NS];
  logic                 r_rneg [NS];
  div_spec_e            r_spec [NS];
  logic [DW-1:0]        r_dvd  [NS];
  logic [TAG_WIDTH-1:0] r_tag  [NS];

  logic [DW:0]   w_a_in  [NS];
  logic [DW:0]   w_m_in  [NS];
  logic [DW-1:0] w_q_in  [NS];
  logic [DW:0]   w_a_out [NS];
  logic [DW-1:0] w_q_out [NS];

  generate
    for (genvar k = 0; k < NS; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign w_a_in[k] = '0;
        assign w_m_in[k] = {1'b0, w_abs_b};
        assign w_q_in[k] = w_abs_a;
      end else begin : g_rest
        assign w_a_in[k] = r_a[k-1];
        assign w_m_in[k] = r_m[k-1];
        assign w_q_in[k] = r_q[k-1];
      end

      div_nr_stage #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BITS_PER_STAGE (BITS_PER_STAGE)
      ) u_stage (
        .i_a (w_a_in[k]),
        .i_m (w_m_in[k]),
        .i_q (w_q_in[k]),
        .o_a (w_a_out[k]),
        .o_q (w_q_out[k])
      );
    end
  endgenerate

  // output fix-up from the last stage
  logic [DW:0]   w_rem_full;
  logic [DW-1:0] w_quo, w_rem, w_result;

  always_comb begin
    w_rem_full = r_a[NS-1][DW] ? (r_a[NS-1] + r_m[NS-1]) : r_a[NS-1];
    w_quo      = r_qneg[NS-1] ? -r_q[NS-1] : r_q[NS-1];
    w_rem      = r_rneg[NS-1] ? -w_rem_full[DW-1:0] : w_rem_full[DW-1:0];
    case (r_spec[NS-1])
      SPEC_DIV0: begin
        w_quo = '1;
        w_rem = r_dvd[NS-1];
      end
      SPEC_OVF: begin
        w_quo = r_dvd[NS-1];
        w_rem = '0;
      end
      default: ;
    endcase
    w_result = r_rem[NS-1] ? w_rem : w_quo;
  end

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      for (int k = 0; k < NS; k++) begin
        r_a[k]    <= '0;
        r_q[k]    <= '0;
        r_m[k]    <= '0;
        r_rem[k]  <= 1'b0;
        r_qneg[k] <= 1'b0;
        r_rneg[k] <= 1'b0;
        r_spec[k] <= SPEC_NONE;
        r_dvd[k]  <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      if (w_adv) begin
        r_vld[0]  <= in_valid;
        r_rem[0]  <= in_op[OP_BIT_REM];
        r_qneg[0] <= w_qneg;
        r_rneg[0] <= w_sa;
        r_spec[0] <= w_spec;
        r_dvd[0]  <= in_dividend;
        r_tag[0]  <= in_tag;
        for (int k = 1; k < NS; k++) begin
          r_vld[k]  <= r_vld[k-1];
          r_rem[k]  <= r_rem[k-1];
          r_qneg[k] <= r_qneg[k-1];
          r_rneg[k] <= r_rneg[k-1];
          r_spec[k] <= r_spec[k-1];
          r_dvd[k]  <= r_dvd[k-1];
          r_tag[k]  <= r_tag[k-1];
        end
        for (int k = 0; k < NS; k++) begin
          r_a[k] <= w_a_out[k];
          r_q[k] <= w_q_out[k];
          r_m[k] <= w_m_in[k];
        end
        r_out_valid  <= r_vld[NS-1];
        r_out_result <= w_result;
        r_out_tag    <= r_tag[NS-1];
      end
      // flush wins over the shift, killing the incoming op as well
      if (flush) begin
        r_vld       <= '0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_div_pipe_nr.sv
// Directed and small random checks of div_pipe_nr: latency, signed/unsigned
// results, special cases, backpressure, flush and mid-stream reset.
module tb_div_pipe_nr
  import div_pkg::*;
#(
  parameter int DW  = 32,
  parameter int BPS = 2,
  parameter int TW  = 5
);

  localparam int NS = DW / BPS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] res_q [$];
  logic [TW-1:0] tag_q [$];

  always #5 clk = ~clk;

  div_pipe_nr #(
    .DATA_WIDTH     (DW),
    .BITS_PER_STAGE (BPS),
    .TAG_WIDTH      (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag)
  );

  // every completed output handshake is recorded in order
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_q.push_back(out_result);
      tag_q.push_back(out_tag);
    end
  end

  function automatic logic [DW-1:0] ref_div(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] q, r, minv;
    minv = '0;
    minv[DW-1] = 1'b1;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!op[0] && a == minv && b == '1) begin
      q = a;
      r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_dividend = a;
    in_divisor = b;
    in_tag = t;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int c;
    c = 0;
    while (res_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_dividend = '0; in_divisor = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b result=%h tag=%h, required 0/0/0", out_valid, out_result, out_tag);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    res_q.delete(); tag_q.delete();
    in_valid = 1'b1; in_op = DIV_OP_DIVU; in_dividend = DW'(100); in_divisor = DW'(7); in_tag = TW'(3);
    @(posedge clk); #1;
    in_op = DIV_OP_REMU; in_tag = TW'(4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 2; c < NS; c++) begin
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: out_valid=%b one cycle before expected, required 0", out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_result !== DW'(14) || out_tag !== TW'(3)) begin
      bad++;
      $display("FAIL latency_divu: valid=%b result=%0d tag=%0d, required 1/14/3", out_valid, out_result, out_tag);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_result !== DW'(2) || out_tag !== TW'(4)) begin
      bad++;
      $display("FAIL latency_remu: valid=%b result=%0d tag=%0d, required 1/2/4", out_valid, out_result, out_tag);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_tail: out_valid=%b after last result, required 0", out_valid);
    end
  endtask

  // runs a batch of 8 directed ops and checks results and tags in order
  task automatic test_directed();
    logic [1:0]    ops [8];
    logic [DW-1:0] as  [8];
    logic [DW-1:0] bs  [8];
    logic [DW-1:0] exp_r [8];
    logic [DW-1:0] minv, r;
    logic [TW-1:0] t;
    minv = '0; minv[DW-1] = 1'b1;
    // signed rounding toward zero, remainder takes dividend sign
    ops[0] = DIV_OP_DIV;  as[0] = DW'(-7); bs[0] = DW'(2);  exp_r[0] = DW'(-3);
    ops[1] = DIV_OP_REM;  as[1] = DW'(-7); bs[1] = DW'(2);  exp_r[1] = DW'(-1);
    ops[2] = DIV_OP_DIV;  as[2] = DW'(7);  bs[2] = DW'(-2); exp_r[2] = DW'(-3);
    ops[3] = DIV_OP_REM;  as[3] = DW'(7);  bs[3] = DW'(-2); exp_r[3] = DW'(1);
    // divide by zero
    ops[4] = DIV_OP_DIV;  as[4] = DW'(16'h1234); bs[4] = '0; exp_r[4] = '1;
    ops[5] = DIV_OP_REMU; as[5] = DW'(16'h1234); bs[5] = '0; exp_r[5] = DW'(16'h1234);
    // signed overflow
    ops[6] = DIV_OP_DIV;  as[6] = minv; bs[6] = '1; exp_r[6] = minv;
    ops[7] = DIV_OP_REM;  as[7] = minv; bs[7] = '1; exp_r[7] = '0;
    res_q.delete(); tag_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(ops[i], as[i], bs[i], TW'(i + 8));
    wait_results(8, NS + 30);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (res_q.size() == 0) begin
        bad++;
        $display("FAIL directed_%0d: no result, required %h", i, exp_r[i]);
      end else begin
        r = res_q.pop_front();
        t = tag_q.pop_front();
        if (r !== exp_r[i] || t !== TW'(i + 8)) begin
          bad++;
          $display("FAIL directed_%0d: result=%h tag=%0d, required %h tag=%0d", i, r, t, exp_r[i], i + 8);
        end
      end
    end
  endtask

  task automatic test_edges();
    logic [1:0]    ops [6];
    logic [DW-1:0] as  [6];
    logic [DW-1:0] bs  [6];
    logic [DW-1:0] exp_r [6];
    logic [DW-1:0] minv, r;
    logic [TW-1:0] t;
    minv = '0; minv[DW-1] = 1'b1;
    ops[0] = DIV_OP_DIVU; as[0] = '1;       bs[0] = DW'(1);   exp_r[0] = '1;
    ops[1] = DIV_OP_REMU; as[1] = DW'(5);   bs[1] = '1;       exp_r[1] = DW'(5);
    ops[2] = DIV_OP_DIV;  as[2] = minv;     bs[2] = DW'(2);   exp_r[2] = {2'b11, {(DW-2){1'b0}}};
    ops[3] = DIV_OP_DIVU; as[3] = minv;     bs[3] = '1;       exp_r[3] = '0;
    ops[4] = DIV_OP_REM;  as[4] = DW'(-5);  bs[4] = '0;       exp_r[4] = DW'(-5);
    ops[5] = DIV_OP_DIVU; as[5] = DW'(100); bs[5] = DW'(100); exp_r[5] = DW'(1);
    res_q.delete(); tag_q.delete();
    for (int i = 0; i < 6; i++) issue(ops[i], as[i], bs[i], TW'(20 + i));
    wait_results(6, NS + 30);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (res_q.size() == 0) begin
        bad++;
        $display("FAIL edge_%0d: no result, required %h", i, exp_r[i]);
      end else begin
        r = res_q.pop_front();
        t = tag_q.pop_front();
        if (r !== exp_r[i] || t !== TW'(20 + i)) begin
          bad++;
          $display("FAIL edge_%0d: result=%h tag=%0d, required %h tag=%0d", i, r, t, exp_r[i], 20 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]    ops [20];
    logic [DW-1:0] as  [20];
    logic [DW-1:0] bs  [20];
    logic [DW-1:0] exp_r [$];
    logic [TW-1:0] exp_t [$];
    logic [DW-1:0] held_r, r, e;
    logic [TW-1:0] held_t, t, et;
    logic          held;
    int            issued, cyc;
    for (int i = 0; i < 20; i++) begin
      ops[i] = 2'($urandom_range(0, 3));
      as[i]  = DW'($urandom);
      bs[i]  = (i % 7 == 3) ? '0 : ((i % 2 == 1) ? DW'($urandom_range(1, 300)) : DW'($urandom));
    end
    res_q.delete(); tag_q.delete();
    issued = 0; cyc = 0; held = 1'b0; held_r = '0; held_t = '0;
    while ((issued < 20 || res_q.size() < 20) && cyc < 400) begin
      out_ready = !(cyc >= NS + 4 && cyc < NS + 9);
      if (issued < 20) begin
        in_valid = 1'b1; in_op = ops[issued]; in_dividend = as[issued];
        in_divisor = bs[issued]; in_tag = TW'(issued);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || out_result !== held_r || out_tag !== held_t) begin
          bad++;
          $display("FAIL bp_hold: valid=%b result=%h tag=%0d, required 1 %h tag=%0d",
                   out_valid, out_result, out_tag, held_r, held_t);
        end
      end
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_in_ready: got %b while stalled, required 0", in_ready);
        end
      end
      held   = out_valid & ~out_ready;
      held_r = out_result;
      held_t = out_tag;
      if (in_valid && in_ready) begin
        exp_r.push_back(ref_div(ops[issued], as[issued], bs[issued]));
        exp_t.push_back(TW'(issued));
        issued++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (res_q.size() != 20) begin
      bad++;
      $display("FAIL bp_count: got %0d results, required 20", res_q.size());
    end
    while (exp_r.size() > 0) begin
      e  = exp_r.pop_front();
      et = exp_t.pop_front();
      total++;
      if (res_q.size() == 0) begin
        bad++;
        $display("FAIL bp_result: missing result, required %h tag=%0d", e, et);
      end else begin
        r = res_q.pop_front();
        t = tag_q.pop_front();
        if (r !== e || t !== et) begin
          bad++;
          $display("FAIL bp_result: result=%h tag=%0d, required %h tag=%0d", r, t, e, et);
        end
      end
    end
  endtask

  task automatic test_flush();
    res_q.delete(); tag_q.delete();
    out_ready = 1'b1;
    issue(DIV_OP_DIVU, DW'(9), DW'(3), TW'(1));
    issue(DIV_OP_DIVU, DW'(8), DW'(2), TW'(2));
    issue(DIV_OP_REMU, DW'(8), DW'(3), TW'(3));
    in_valid = 1'b1; in_op = DIV_OP_DIVU; in_dividend = DW'(6); in_divisor = DW'(2); in_tag = TW'(7);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    issue(DIV_OP_DIVU, DW'(50), DW'(5), TW'(9));
    wait_results(1, NS + 10);
    repeat (NS + 4) @(posedge clk);
    #1;
    total++;
    if (res_q.size() != 1) begin
      bad++;
      $display("FAIL flush_count: got %0d results, required 1", res_q.size());
    end
    total++;
    if (res_q.size() == 0 || res_q[0] !== DW'(10) || tag_q[0] !== TW'(9)) begin
      bad++;
      $display("FAIL flush_result: result=%h tag=%h, required 10 tag=9",
               (res_q.size() > 0) ? res_q[0] : '0, (tag_q.size() > 0) ? tag_q[0] : '0);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    res_q.delete(); tag_q.delete();
    out_ready = 1'b0;
    issue(DIV_OP_DIVU, DW'(40), DW'(4), TW'(11));
    issue(DIV_OP_DIVU, DW'(30), DW'(3), TW'(12));
    issue(DIV_OP_DIVU, DW'(20), DW'(2), TW'(13));
    n = 0;
    while (!out_valid && n < NS + 10) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (out_valid !== 1'b1 || out_tag !== TW'(11)) begin
      bad++;
      $display("FAIL rst_pre_valid: valid=%b tag=%0d, required 1 tag=11", out_valid, out_tag);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL rst_async: valid=%b result=%h tag=%h, required 0/0/0", out_valid, out_result, out_tag);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    res_q.delete(); tag_q.delete();
    issue(DIV_OP_REMU, DW'(50), DW'(7), TW'(14));
    wait_results(1, NS + 10);
    repeat (NS + 4) @(posedge clk);
    #1;
    total++;
    if (res_q.size() != 1) begin
      bad++;
      $display("FAIL rst_count: got %0d results, required 1", res_q.size());
    end
    total++;
    if (res_q.size() == 0 || res_q[0] !== DW'(1) || tag_q[0] !== TW'(14)) begin
      bad++;
      $display("FAIL rst_result: result=%h tag=%h, required 1 tag=14",
               (res_q.size() > 0) ? res_q[0] : '0, (tag_q.size() > 0) ? tag_q[0] : '0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_edges();
    test_backpressure();
    test_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
